// File: rtl/dram_read_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : dram_read_master
// Description : Word-granular DRAM read engine. Turns image-sender requests
//               into AXI4 INCR read bursts, splitting at 4 KB boundaries,
//               and packs narrow R beats into wide words with a one-cycle
//               valid strobe. One burst in flight, one request queued.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_read_master #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int DRAM_DATA_WIDTH = 512
) (
  input  logic                       clk_pixel,
  input  logic                       dram_reader_reset,
  input  logic                       dram_reader_flush,
  input  logic [AXI_ADDR_WIDTH-1:0]  dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       dram_read_busy,
  output logic                       dram_read_error,
  output logic [AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam int BEATS      = DRAM_DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int WORD_BYTES = DRAM_DATA_WIDTH / 8;
  localparam int WB_LOG     = $clog2(WORD_BYTES);
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW         = 13;  // wide enough for 4096 and word counts
  localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [2:0]                ARSIZE    = 3'($clog2(AXI_DATA_WIDTH / 8));
  localparam logic [AXI_ADDR_WIDTH-1:0] WORD_MASK = ~AXI_ADDR_WIDTH'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AR    = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                      r_state;
  logic [AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic [7:0]                  r_arlen;
  logic                        r_arvalid;
  logic                        r_rready;
  logic [DRAM_DATA_WIDTH-1:0]  r_data;
  logic                        r_valid;
  logic                        r_error;
  logic [BEAT_W-1:0]           r_beat;
  logic [DRAM_DATA_WIDTH-1:0]  r_buf;
  logic                        r_flushed;
  logic                        r_pend_valid;
  logic [AXI_ADDR_WIDTH-1:0]   r_pend_addr;
  logic [CW-1:0]               r_pend_words;
  logic                        r_rem_valid;
  logic [AXI_ADDR_WIDTH-1:0]   r_rem_addr;
  logic [CW-1:0]               r_rem_words;

  logic [AXI_ADDR_WIDTH-1:0]   w_req_addr;
  logic                        w_len_big;
  logic [CW-1:0]               w_req_words;
  logic                        w_ar_hs, w_r_hs, w_word_end, w_burst_end, w_data_end;
  logic                        w_take_rem, w_take_pend, w_req, w_req_cur, w_req_pend, w_req_drop;
  logic                        w_issue;
  logic [AXI_ADDR_WIDTH-1:0]   w_src_addr;
  logic [CW-1:0]               w_src_words, w_room, w_first, w_rest;
  logic [AXI_ADDR_WIDTH-1:0]   w_next_page;
  logic [DRAM_DATA_WIDTH-1:0]  w_word;

  assign w_req_addr  = dram_read_addr & WORD_MASK;
  assign w_len_big   = dram_read_len > 8'd63;
  assign w_req_words = w_len_big ? CW'(64) : CW'(dram_read_len[5:0]) + CW'(1);

  assign w_ar_hs     = r_arvalid & m_axi_arready;
  assign w_r_hs      = r_rready & m_axi_rvalid;
  assign w_word_end  = w_r_hs & (r_beat == LAST_BEAT);
  assign w_burst_end = w_r_hs & m_axi_rlast;
  // A burst in DATA ending without flush chains into the next piece of work
  assign w_data_end  = (r_state == S_DATA) & w_burst_end & ~dram_reader_flush;
  assign w_take_rem  = w_data_end & r_rem_valid;
  assign w_take_pend = r_pend_valid & ~dram_reader_flush &
                       ((r_state == S_IDLE) | (w_data_end & ~r_rem_valid));

  // A freed pending slot may be refilled in the same cycle it is consumed
  assign w_req       = dram_read_en & ~dram_reader_flush;
  assign w_req_cur   = w_req & (r_state == S_IDLE) & ~r_pend_valid;
  assign w_req_pend  = w_req & ~w_req_cur & (~r_pend_valid | w_take_pend);
  assign w_req_drop  = w_req & ~w_req_cur & ~w_req_pend;
  assign w_issue     = w_take_rem | w_take_pend | w_req_cur;

  // Select which work item feeds the burst-sizing logic this cycle
  always_comb begin
    w_src_addr  = w_req_addr;
    w_src_words = w_req_words;
    if (w_take_rem) begin
      w_src_addr  = r_rem_addr;
      w_src_words = r_rem_words;
    end else if (w_take_pend) begin
      w_src_addr  = r_pend_addr;
      w_src_words = r_pend_words;
    end
  end

  // Words left before the 4 KB page ends; the rest restarts on the next page
  assign w_room      = (CW'(4096) - CW'(w_src_addr[11:0])) >> WB_LOG;
  assign w_first     = (w_src_words < w_room) ? w_src_words : w_room;
  assign w_rest      = w_src_words - w_first;
  assign w_next_page = {w_src_addr[AXI_ADDR_WIDTH-1:12] + (AXI_ADDR_WIDTH-12)'(1), 12'h000};

  // Merge the incoming beat into the partial word at its beat position
  always_comb begin
    w_word = r_buf;
    w_word[r_beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = m_axi_rdata;
  end

  // Control FSM, request queueing, beat packing and error capture
  always_ff @(posedge clk_pixel) begin
    if (dram_reader_reset) begin
      r_state      <= S_IDLE;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_error      <= 1'b0;
      r_beat       <= '0;
      r_buf        <= '0;
      r_flushed    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_words <= '0;
      r_rem_valid  <= 1'b0;
      r_rem_addr   <= '0;
      r_rem_words  <= '0;
    end else begin
      r_valid <= 1'b0;

      if ((w_req & w_len_big) | w_req_drop | (w_r_hs & (m_axi_rresp != 2'b00)) |
          (w_burst_end & (r_beat != LAST_BEAT)))
        r_error <= 1'b1;

      // An early rlast restarts packing so the partial word is discarded
      if (w_r_hs) begin
        r_buf  <= w_word;
        r_beat <= m_axi_rlast ? '0 : r_beat + BEAT_W'(1);
      end

      if ((r_state == S_DATA) & w_word_end & ~dram_reader_flush) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
      end

      if (w_req_pend) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= w_req_addr;
        r_pend_words <= w_req_words;
      end else if (w_take_pend) begin
        r_pend_valid <= 1'b0;
      end

      if (dram_reader_flush) begin
        r_pend_valid <= 1'b0;
        r_rem_valid  <= 1'b0;
      end

      case (r_state)
        S_AR: begin
          // The address handshake must complete even when flushed
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= (r_flushed | dram_reader_flush) ? S_DRAIN : S_DATA;
            r_flushed <= 1'b0;
          end else if (dram_reader_flush) begin
            r_flushed <= 1'b1;
          end
        end
        S_DATA: begin
          if (dram_reader_flush) begin
            if (w_burst_end) begin
              r_state  <= S_IDLE;
              r_rready <= 1'b0;
            end else begin
              r_state  <= S_DRAIN;
            end
          end else if (w_burst_end & ~w_issue) begin
            r_state  <= S_IDLE;
            r_rready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_burst_end) begin
            r_state  <= S_IDLE;
            r_rready <= 1'b0;
          end
        end
        default: ;
      endcase

      // Launching a burst overrides the state chosen above
      if (w_issue) begin
        r_state     <= S_AR;
        r_arvalid   <= 1'b1;
        r_rready    <= 1'b0;
        r_araddr    <= w_src_addr;
        r_arlen     <= 8'(w_first * CW'(BEATS) - CW'(1));
        r_rem_valid <= (w_rest != '0);
        r_rem_addr  <= w_next_page;
        r_rem_words <= w_rest;
      end
    end
  end

  assign dram_read_data       = r_data;
  assign dram_read_data_valid = r_valid;
  assign dram_read_busy       = (r_state != S_IDLE) | r_pend_valid;
  assign dram_read_error      = r_error;
  assign m_axi_araddr         = r_araddr;
  assign m_axi_arlen          = r_arlen;
  assign m_axi_arsize         = ARSIZE;
  assign m_axi_arburst        = 2'b01;
  assign m_axi_arvalid        = r_arvalid;
  assign m_axi_rready         = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_dram_read_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dram_read_master
// Description : Self-checking bench for dram_read_master: randomized AXI
//               slave, word-level reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_read_master;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int WW = 512;
  localparam int LIMIT = 5000;

  logic          clk_pixel = 1'b0;
  logic          dram_reader_reset, dram_reader_flush, dram_read_en;
  logic [AW-1:0] dram_read_addr;
  logic [7:0]    dram_read_len;
  logic [WW-1:0] dram_read_data;
  logic          dram_read_data_valid, dram_read_busy, dram_read_error;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

  always #5 clk_pixel = ~clk_pixel;

  dram_read_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .DRAM_DATA_WIDTH(WW)) dut (
    .clk_pixel(clk_pixel), .dram_reader_reset(dram_reader_reset),
    .dram_reader_flush(dram_reader_flush), .dram_read_addr(dram_read_addr),
    .dram_read_len(dram_read_len), .dram_read_en(dram_read_en),
    .dram_read_data(dram_read_data), .dram_read_data_valid(dram_read_data_valid),
    .dram_read_busy(dram_read_busy), .dram_read_error(dram_read_error),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory contents: every 16-byte beat is a function of its byte address
  function automatic logic [DW-1:0] beat_of(input logic [AW-1:0] a);
    return {a ^ 32'hA5A5_0000, ~a, a + 32'h1234_5678, a};
  endfunction
  function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a);
    return {beat_of(a + 32'd48), beat_of(a + 32'd32), beat_of(a + 32'd16), beat_of(a)};
  endfunction

  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] got_q[$];
  logic [AW-1:0] ar_addr_log[$];
  logic [7:0]    ar_len_log[$];

  // Slave state
  logic [AW-1:0] sb_addr, p_araddr;
  logic [7:0]    p_arlen;
  int            sb_beats, sb_bi;
  bit            sb_active, p_ar_hs, p_r_hs, word_end_prev, hold;
  int            err_idx = -1, early_idx = -1;
  bit            vcheck = 1'b1;

  // AXI slave plus output monitor, acting 1 time unit after each rising edge
  initial begin
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0; m_axi_rresp = 0;
    sb_active = 0; sb_bi = 0; p_ar_hs = 0; p_r_hs = 0; sb_addr = '0; sb_beats = 0;
    p_araddr = '0; p_arlen = '0;
    forever begin
      @(posedge clk_pixel); #1;
      word_end_prev = 0;
      if (dram_reader_reset) begin
        sb_active = 0; sb_bi = 0; p_ar_hs = 0; p_r_hs = 0;
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_arready = 0; m_axi_rresp = 0;
      end else begin
        if (p_r_hs) begin
          word_end_prev = (sb_bi % 4 == 3);
          if (m_axi_rlast) begin sb_active = 0; sb_bi = 0; end
          else sb_bi++;
        end
        if (p_ar_hs) begin
          sb_active = 1; sb_bi = 0; sb_addr = p_araddr; sb_beats = int'(p_arlen) + 1;
          ar_addr_log.push_back(p_araddr);
          ar_len_log.push_back(p_arlen);
          chk("ar_in_page", 1'((int'(p_araddr[11:0]) + sb_beats * 16) <= 4096), 1'b1);
          chk("ar_whole_words", 1'(sb_beats % 4 == 0), 1'b1);
        end
        if (vcheck && (word_end_prev || dram_read_data_valid))
          chk("valid_timing", dram_read_data_valid, word_end_prev);
        if (dram_read_data_valid) got_q.push_back(dram_read_data);

        hold = m_axi_rvalid && !p_r_hs;
        m_axi_arready = ($urandom_range(0, 3) != 0);
        if (!hold) begin
          if (sb_active && $urandom_range(0, 3) != 0) begin
            m_axi_rvalid = 1;
            m_axi_rdata  = beat_of(sb_addr + 32'(sb_bi * 16));
            m_axi_rlast  = (sb_bi == sb_beats - 1) || (sb_bi == early_idx);
            m_axi_rresp  = (sb_bi == err_idx) ? 2'b10 : 2'b00;
          end else begin
            m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
          end
        end
        p_ar_hs = m_axi_arvalid && m_axi_arready;
        if (p_ar_hs) begin p_araddr = m_axi_araddr; p_arlen = m_axi_arlen; end
        p_r_hs = m_axi_rvalid && m_axi_rready;
      end
    end
  end

  // Reference model: a request is just len+1 consecutive 64-byte words
  task automatic expect_req(input logic [AW-1:0] a, input logic [7:0] l);
    logic [AW-1:0] base;
    int n;
    base = a & ~32'd63;
    n = (l > 8'd63) ? 64 : int'(l) + 1;
    for (int i = 0; i < n; i++) exp_q.push_back(word_of(base + 32'(i * 64)));
  endtask

  // Called at a falling edge; returns at the falling edge after sampling
  task automatic send(input logic [AW-1:0] a, input logic [7:0] l);
    dram_read_en = 1; dram_read_addr = a; dram_read_len = l;
    @(negedge clk_pixel);
    dram_read_en = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dram_read_busy && n < LIMIT) begin @(negedge clk_pixel); n++; end
    chk("idle_timeout", 1'(n >= LIMIT), 1'b0);
  endtask

  // Returns at the falling edge just after the rlast handshake
  task automatic wait_rlast();
    int n;
    n = 0;
    while (!(p_r_hs && m_axi_rlast) && n < LIMIT) begin @(negedge clk_pixel); n++; end
    chk("rlast_timeout", 1'(n >= LIMIT), 1'b0);
    @(negedge clk_pixel);
  endtask

  task automatic check_words(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    dram_reader_reset = 1; dram_read_en = 0; dram_reader_flush = 0;
    @(negedge clk_pixel); @(negedge clk_pixel);
    dram_reader_reset = 0;
    got_q.delete(); exp_q.delete(); ar_addr_log.delete(); ar_len_log.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    chk({tag, "_araddr"}, m_axi_araddr, '0);
    chk({tag, "_arlen"}, m_axi_arlen, '0);
    chk({tag, "_rready"}, m_axi_rready, 1'b0);
    chk({tag, "_data"}, dram_read_data, '0);
    chk({tag, "_valid"}, dram_read_data_valid, 1'b0);
    chk({tag, "_busy"}, dram_read_busy, 1'b0);
    chk({tag, "_error"}, dram_read_error, 1'b0);
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;
    logic [7:0]    l;
    dram_reader_reset = 1; dram_reader_flush = 0; dram_read_en = 0;
    dram_read_addr = '0; dram_read_len = '0;
    repeat (3) @(negedge clk_pixel);
    check_all_zero("reset");
    chk("arsize", m_axi_arsize, 3'd4);
    chk("arburst", m_axi_arburst, 2'b01);
    dram_reader_reset = 0;
    @(negedge clk_pixel);

    // Single word
    send(32'h1000_0040, 8'd0);
    expect_req(32'h1000_0040, 8'd0);
    chk("single_busy", dram_read_busy, 1'b1);
    chk("single_arvalid", m_axi_arvalid, 1'b1);
    chk("single_araddr", m_axi_araddr, 32'h1000_0040);
    chk("single_arlen", m_axi_arlen, 8'd3);
    wait_rlast();
    chk("single_busy_fall", dram_read_busy, 1'b0);
    check_words("single");

    // 4 KB split
    ar_addr_log.delete(); ar_len_log.delete();
    send(32'h0000_0FC0, 8'd2);
    expect_req(32'h0000_0FC0, 8'd2);
    wait_idle();
    chk("split_ars", ar_addr_log.size(), 2);
    if (ar_addr_log.size() == 2) begin
      chk("split_addr0", ar_addr_log[0], 32'h0000_0FC0);
      chk("split_len0", ar_len_log[0], 8'd3);
      chk("split_addr1", ar_addr_log[1], 32'h0000_1000);
      chk("split_len1", ar_len_log[1], 8'd7);
    end
    check_words("split");
    chk("split_error", dram_read_error, 1'b0);

    // Randomized traffic, sometimes two back-to-back requests
    for (int i = 0; i < 25; i++) begin
      wait_idle();
      a = $urandom & 32'h0FFF_FFFF;
      if ($urandom_range(0, 2) == 0) a[11:0] = 12'hFC0 - 12'(64 * $urandom_range(0, 7));
      l = 8'($urandom_range(0, 63));
      send(a, l);
      expect_req(a, l);
      if ($urandom_range(0, 1) == 1) begin
        a = ($urandom & 32'h0FFF_FFFF) | 32'h0000_0F00;
        l = 8'($urandom_range(0, 20));
        send(a, l);
        expect_req(a, l);
      end
    end
    wait_idle();
    check_words("random");
    chk("random_error", dram_read_error, 1'b0);

    // Pending slot and overflow
    do_reset();
    send(32'h2000_0000, 8'd3);
    expect_req(32'h2000_0000, 8'd3);
    n = 0;
    while (!m_axi_rready && n < LIMIT) begin @(negedge clk_pixel); n++; end
    chk("pend_rready_timeout", 1'(n >= LIMIT), 1'b0);
    send(32'h3000_0100, 8'd1);
    expect_req(32'h3000_0100, 8'd1);
    chk("pend_error_before", dram_read_error, 1'b0);
    send(32'h4000_0000, 8'd0);
    chk("pend_overflow_error", dram_read_error, 1'b1);
    wait_rlast();
    chk("pend_next_arvalid", m_axi_arvalid, 1'b1);
    chk("pend_next_araddr", m_axi_araddr, 32'h3000_0100);
    chk("pend_next_arlen", m_axi_arlen, 8'd7);
    wait_idle();
    check_words("pend");

    // Over-long length is truncated and flagged
    do_reset();
    send(32'h5000_0000, 8'd200);
    expect_req(32'h5000_0000, 8'd200);
    chk("trunc_error", dram_read_error, 1'b1);
    chk("trunc_arlen", m_axi_arlen, 8'd255);
    wait_idle();
    check_words("trunc");

    // Flush on beat 5 of a 16-beat burst
    do_reset();
    vcheck = 0;
    send(32'h6000_0000, 8'd3);
    exp_q.push_back(word_of(32'h6000_0000));
    n = 0;
    while (!(p_r_hs && sb_bi == 5) && n < LIMIT) begin @(negedge clk_pixel); n++; end
    chk("flush_beat_timeout", 1'(n >= LIMIT), 1'b0);
    dram_reader_flush = 1;
    @(negedge clk_pixel);
    dram_reader_flush = 0;
    chk("flush_drain_rready", m_axi_rready, 1'b1);
    wait_idle();
    chk("flush_rready_off", m_axi_rready, 1'b0);
    chk("flush_slave_done", sb_active, 1'b0);
    check_words("flush");
    chk("flush_error", dram_read_error, 1'b0);
    vcheck = 1;

    // Error response on beat 2
    do_reset();
    err_idx = 2;
    send(32'h7000_0000, 8'd0);
    expect_req(32'h7000_0000, 8'd0);
    wait_idle();
    err_idx = -1;
    check_words("rresp");
    chk("rresp_error", dram_read_error, 1'b1);
    send(32'h7000_1000, 8'd0);
    expect_req(32'h7000_1000, 8'd0);
    wait_idle();
    check_words("rresp_after");
    chk("rresp_error_sticky", dram_read_error, 1'b1);

    // Early rlast on beat 1
    do_reset();
    early_idx = 1;
    send(32'h8000_0000, 8'd0);
    wait_idle();
    early_idx = -1;
    check_words("early");
    chk("early_error", dram_read_error, 1'b1);

    // Reset in the middle of a burst
    do_reset();
    vcheck = 0;
    send(32'h9000_0000, 8'd3);
    n = 0;
    while (!(m_axi_rready && sb_bi >= 2) && n < LIMIT) begin @(negedge clk_pixel); n++; end
    chk("midreset_timeout", 1'(n >= LIMIT), 1'b0);
    dram_reader_reset = 1;
    @(negedge clk_pixel);
    check_all_zero("midreset");
    dram_reader_reset = 0;
    got_q.delete(); exp_q.delete();
    @(negedge clk_pixel);
    vcheck = 1;
    send(32'h9000_0400, 8'd1);
    expect_req(32'h9000_0400, 8'd1);
    wait_idle();
    check_words("after_reset");
    chk("after_reset_error", dram_read_error, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
